// File: rtl/demod_correlator_stream_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : demod_correlator_stream_if
// Brief    : Start/threshold control, segment stream and result handshake
//            bundle for the demodulation correlator.
// Revision : 1.0 - initial release
// ============================================================================
interface demod_correlator_stream_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] threshold;
    logic [DATA_W-1:0] seg_data;
    logic              seg_valid;
    logic              seg_ready;
    logic [DATA_W-1:0] demod_out;
    logic              bit_out;
    logic              valid;
    logic              busy;

    modport master (
        output start,
        output threshold,
        output seg_data,
        output seg_valid,
        input  seg_ready,
        input  demod_out,
        input  bit_out,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        input  threshold,
        input  seg_data,
        input  seg_valid,
        output seg_ready,
        output demod_out,
        output bit_out,
        output valid,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/demod_correlator_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : demod_correlator_stream
// Brief    : Serial +/-1 weighted correlator over N_SEG signed segments with a
//            threshold decision. Define DEMOD_SAT_EN to clamp the final sum
//            instead of wrapping it to DATA_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module demod_correlator_stream #(
    parameter int           DATA_W      = 32,
    parameter int           N_SEG       = 10,
    parameter logic [255:0] REF_PATTERN = 256'h155
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    demod_correlator_stream_if.slave    io_bus
);

    localparam int CNT_W = $clog2(N_SEG);
    localparam int ACC_W = DATA_W + $clog2(N_SEG) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [CNT_W-1:0]          r_seg_cnt;
    logic                      r_drain;
    logic signed [DATA_W:0]    r_prod;
    logic                      r_prod_vld;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]         r_thr;
    logic [DATA_W-1:0]         r_demod;
    logic                      r_bit;
    logic                      r_valid;
    logic                      r_busy;

    logic                      w_start_acc;
    logic                      w_xfer;
    logic                      w_last;
    logic                      w_seg_ready;
    logic [7:0]                w_idx;
    logic                      w_weight;
    logic signed [DATA_W:0]    w_seg_ext;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic [DATA_W-1:0]         w_narrow;
    logic                      w_ge;

    assign w_start_acc = (r_state == S_IDLE) && io_bus.start;
    assign w_xfer      = (r_state == S_COLLECT) && io_bus.seg_valid;
    assign w_last      = w_xfer && (r_seg_cnt == CNT_W'(N_SEG - 1));
    assign w_idx       = 8'(r_seg_cnt);
    assign w_weight    = REF_PATTERN[w_idx];
    // One extra bit so negating the most negative sample stays exact.
    assign w_seg_ext   = {io_bus.seg_data[DATA_W-1], io_bus.seg_data};
    assign w_prod_ext  = {{(ACC_W-DATA_W-1){r_prod[DATA_W]}}, r_prod};

`ifdef DEMOD_SAT_EN
    logic [ACC_W-DATA_W:0] w_acc_hi;
    logic                  w_ovf;

    assign w_acc_hi = r_acc[ACC_W-1:DATA_W-1];
    assign w_ovf    = !((&w_acc_hi) || (~|w_acc_hi));

    always_comb begin
        w_narrow = r_acc[DATA_W-1:0];
        if (w_ovf) begin
            w_narrow = r_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    logic w_unused_acc_hi;

    assign w_unused_acc_hi = &{1'b0, r_acc[ACC_W-1:DATA_W]};

    always_comb begin
        w_narrow = r_acc[DATA_W-1:0];
    end
`endif

    assign w_ge = $signed(w_narrow) >= $signed(r_thr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_seg_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_seg_ready = 1'b1;
                if (w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg_cnt  <= '0;
            r_drain    <= 1'b0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_thr      <= '0;
            r_demod    <= '0;
            r_bit      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_prod_vld <= w_xfer;
            r_drain    <= (r_state == S_DRAIN);
            r_valid    <= (r_state == S_DONE);
            if (w_xfer) begin
                r_prod <= w_weight ? w_seg_ext : -w_seg_ext;
            end
            if (w_start_acc) begin
                r_acc     <= '0;
                r_seg_cnt <= '0;
                r_thr     <= io_bus.threshold;
                r_busy    <= 1'b1;
            end else begin
                if (r_prod_vld) begin
                    r_acc <= r_acc + w_prod_ext;
                end
                if (w_xfer) begin
                    r_seg_cnt <= r_seg_cnt + 1'b1;
                end
            end
            // The final accumulate lands during DRAIN, so DONE sees the full sum.
            if (r_state == S_DONE) begin
                r_demod <= w_narrow;
                r_bit   <= w_ge;
                r_busy  <= 1'b0;
            end
        end
    end

    assign io_bus.seg_ready = w_seg_ready;
    assign io_bus.demod_out = r_demod;
    assign io_bus.bit_out   = r_bit;
    assign io_bus.valid     = r_valid;
    assign io_bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_demod_correlator_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_demod_correlator_stream
// Brief    : Directed scoreboard bench for demod_correlator_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demod_correlator_stream;

    localparam int DATA_W = 32;
    localparam int N_SEG  = 10;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] d;
        logic        b;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    demod_correlator_stream_if #(.DATA_W(DATA_W)) bus ();

    demod_correlator_stream #(
        .DATA_W      (DATA_W),
        .N_SEG       (N_SEG),
        .REF_PATTERN (256'h155)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_xfer = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] segs[N_SEG];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] thr);
        longint      sum;
        longint      v;
        logic [9:0]  pat;
        logic [31:0] n;
        exp_t        r;
        sum = 0;
        pat = 10'h155;
        for (int i = 0; i < N_SEG; i++) begin
            v   = longint'($signed(segs[i]));
            sum = pat[i] ? sum + v : sum - v;
        end
`ifdef DEMOD_SAT_EN
        if (sum > MAXV)      n = 32'h7FFF_FFFF;
        else if (sum < MINV) n = 32'h8000_0000;
        else                 n = sum[31:0];
`else
        n = sum[31:0];
`endif
        r.d = n;
        r.b = ($signed(n) >= $signed(thr));
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.seg_valid && bus.seg_ready) last_xfer <= cyc + 1;
    end

    // Result monitor: every valid pulse must match the oldest pending symbol.
    always @(negedge clk) begin
        if (bus.valid) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("demod_out", bus.demod_out, mon_e.d);
                chk("bit_out", 32'(bus.bit_out), 32'(mon_e.b));
                chk("latency", 32'(cyc - last_xfer), 32'd3);
            end
        end
    end

    task automatic fill_const(input logic [31:0] ev, input logic [31:0] od);
        for (int i = 0; i < N_SEG; i++) segs[i] = (i % 2 == 0) ? ev : od;
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic begin_symbol(input logic [31:0] thr, input bit push);
        bus.start     = 1'b1;
        bus.threshold = thr;
        if (push) sb.push_back(model(thr));
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic send_segs(input int n, input int max_gap, input int poke_at);
        int gap;
        int k;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(max_gap, 0));
            repeat (gap) begin
                bus.seg_valid = 1'b0;
                @(negedge clk);
            end
            bus.seg_valid = 1'b1;
            bus.seg_data  = segs[i];
            if (i == poke_at) bus.start = 1'b1;
            k = 0;
            while (!bus.seg_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("seg_ready_wait", 32'(bus.seg_ready), 32'd1);
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.seg_valid = 1'b0;
    endtask

    task automatic wait_result();
        int k;
        k = 0;
        while (!bus.valid && k < 20) begin
            chk("ready_low_drain", 32'(bus.seg_ready), 32'd0);
            chk("busy_drain", 32'(bus.busy), 32'd1);
            @(negedge clk);
            k++;
        end
        chk("valid_seen", 32'(bus.valid), 32'd1);
        chk("busy_at_valid", 32'(bus.busy), 32'd0);
        chk("ready_at_valid", 32'(bus.seg_ready), 32'd0);
    endtask

    task automatic run(input logic [31:0] thr, input int max_gap, input int poke_at);
        begin_symbol(thr, 1'b1);
        send_segs(N_SEG, max_gap, poke_at);
        wait_result();
        @(negedge clk);
        chk("valid_pulse_end", 32'(bus.valid), 32'd0);
    endtask

    initial begin
        int k;
        bus.start     = 1'b0;
        bus.threshold = '0;
        bus.seg_data  = '0;
        bus.seg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg_ready", 32'(bus.seg_ready), 32'd0);
        chk("rst_demod", bus.demod_out, 32'd0);
        chk("rst_bit", 32'(bus.bit_out), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Start with seg_valid already high: no segment may be taken in IDLE.
        fill_const(32'h0001_0000, 32'h0001_0000);
        bus.seg_valid = 1'b1;
        bus.seg_data  = 32'h7FFF_0000;
        run(32'h1000_0000, 0, -1);
        run(32'h0000_0000, 0, -1);

        fill_const(32'h0001_0000, 32'hFFFF_0000);
        run(32'h1000_0000, 0, -1);
        run(32'h0005_0000, 0, -1);
        run(32'h000A_0000, 0, -1);
        run(32'h000A_0001, 0, -1);

        fill_const(32'h7FFF_FFFF, 32'h8000_0000);
        run(32'h0000_0000, 0, -1);
        run(32'hFFFF_0000, 0, -1);

        fill_const(32'h0001_0000, 32'hFFFF_0000);
        run(32'h0005_0000, 5, -1);
        run(32'h1000_0000, 5, -1);

        // Abort after four transfers; the partial symbol must never complete.
        fill_const(32'h7FFF_FFFF, 32'h8000_0000);
        begin_symbol(32'h0000_1000, 1'b0);
        send_segs(4, 0, -1);
        #2 reset = 1'b0;
        #1;
        chk("abort_seg_ready", 32'(bus.seg_ready), 32'd0);
        chk("abort_demod", bus.demod_out, 32'd0);
        chk("abort_bit", 32'(bus.bit_out), 32'd0);
        chk("abort_valid", 32'(bus.valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        fill_const(32'h0001_0000, 32'h0001_0000);
        run(32'h1000_0000, 0, -1);

        fill_const(32'h0001_0000, 32'hFFFF_0000);
        run(32'h0005_0000, 0, 4);

        // Back-to-back: the second start lands in the first symbol's valid cycle.
        begin_symbol(32'h1000_0000, 1'b1);
        send_segs(N_SEG, 0, -1);
        wait_result();
        fill_const(32'h7FFF_FFFF, 32'h8000_0000);
        begin_symbol(32'h0005_0000, 1'b1);
        send_segs(N_SEG, 2, -1);
        wait_result();
        @(negedge clk);

        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
